// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game core.
package mole_pkg;

  typedef enum logic [1:0] {
    GAP,
    SHOW,
    HIT,
    MISS
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Feedback taps 8,6,5,4 (1-based) map to bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [4:0] NO_KEY    = 5'h10;

endpackage

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column drive, row synchroniser, debounce and release lock.
// Reports only game keys (columns 0 and 1) as a one-clock key_valid pulse.
module keypad_scan
  import mole_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50_000,
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [4:0]       scan_code;
  logic [4:0]       scan_next;
  logic [4:0]       last_code;
  logic [7:0]       db_cnt;
  logic [7:0]       db_next;
  logic             locked;
  logic             slot_end;
  logic             scan_end;

  always_comb begin
    col      = ~(4'b0001 << col_idx);
    slot_end = (div == DIV_W'(SCAN_DIV - 1));
    scan_end = slot_end && (col_idx == 2'd3);
    // Only the first closed game key of the scan is kept; downward loop makes lowest row win.
    scan_next = scan_code;
    if (slot_end && !col_idx[1] && (scan_code == NO_KEY)) begin
      for (int unsigned r = 4; r > 0; r--) begin
        if (!row_sync[r-1]) scan_next = {1'b0, col_idx, 2'(r - 1)};
      end
    end
    db_next = 8'd1;
    if (scan_code == last_code) begin
      db_next = (db_cnt >= 8'(DEBOUNCE)) ? db_cnt : db_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div       <= '0;
      col_idx   <= '0;
      row_meta  <= '1;
      row_sync  <= '1;
      scan_code <= NO_KEY;
      last_code <= NO_KEY;
      db_cnt    <= '0;
      locked    <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= 1'b0;
      row_meta  <= row;
      row_sync  <= row_meta;
      if (slot_end) begin
        div     <= '0;
        col_idx <= col_idx + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
      if (scan_end) begin
        scan_code <= NO_KEY;
        if (scan_code == NO_KEY) begin
          last_code <= NO_KEY;
          db_cnt    <= '0;
          locked    <= 1'b0;
        end else begin
          last_code <= scan_code;
          db_cnt    <= db_next;
          if ((db_next == 8'(DEBOUNCE)) && !locked) begin
            key_valid <= 1'b1;
            key_code  <= scan_code[3:0];
            locked    <= 1'b1;
          end
        end
      end else begin
        scan_code <= scan_next;
      end
    end
  end

endmodule

// File: rtl/mole_keypad_game.sv
// Whack-a-mole core: LFSR mole placement, round timing, scoring and buzzer.
// Define MISS_BEEP_EN to make a miss sound a lower, shorter tone.
module mole_keypad_game
  import mole_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50_000,
  parameter int unsigned DEBOUNCE  = 2,
  parameter int unsigned ROUND_CYC = 50_000_000,
  parameter int unsigned GAP_CYC   = 10_000_000,
  parameter int unsigned BEEP_CYC  = 10_000_000,
  parameter int unsigned TONE_DIV  = 25_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [7:0] led,
  output logic [3:0] col,
  output logic       buzzer
);

  state_t      state;
  state_t      state_next;
  logic [31:0] timer;
  logic [31:0] tone_cnt;
  logic [31:0] tone_half;
  logic        beeping;
  logic [2:0]  idx;
  logic [2:0]  pick;
  logic [7:0]  lfsr;
  logic [7:0]  score;
  logic        key_valid;
  logic [3:0]  key_code;

  keypad_scan #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= GAP;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    beeping    = 1'b0;
    tone_half  = 32'(TONE_DIV);
    pick       = lfsr[2:0];
    if (pick == idx) pick = pick + 3'd1;
    case (state)
      GAP: if (timer == 32'(GAP_CYC - 1)) state_next = SHOW;
      SHOW: begin
        // A key registering on the expiry clock takes priority over the timeout.
        if (key_valid)                         state_next = (key_code == {1'b0, idx}) ? HIT : MISS;
        else if (timer == 32'(ROUND_CYC - 1))  state_next = MISS;
      end
      HIT: begin
        beeping = 1'b1;
        if (timer == 32'(BEEP_CYC - 1)) state_next = GAP;
      end
      MISS: begin
`ifdef MISS_BEEP_EN
        beeping   = 1'b1;
        tone_half = 32'(TONE_DIV * 2);
        if (timer == 32'(BEEP_CYC / 2 - 1)) state_next = GAP;
`else
        state_next = GAP;
`endif
      end
      default: state_next = GAP;
    endcase
    led = (state == SHOW) ? (8'b0000_0001 << idx) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= LFSR_SEED;
      timer    <= '0;
      idx      <= '0;
      score    <= '0;
      tone_cnt <= '0;
      buzzer   <= 1'b0;
    end else begin
      lfsr  <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
      timer <= (state_next != state) ? '0 : timer + 32'd1;
      if (state == GAP && state_next == SHOW) idx <= pick;
      if (state == SHOW && state_next == HIT) score <= score + 8'd1;
      if (beeping && state_next == state) begin
        if (tone_cnt == tone_half - 32'd1) begin
          tone_cnt <= '0;
          buzzer   <= ~buzzer;
        end else begin
          tone_cnt <= tone_cnt + 32'd1;
        end
      end else begin
        tone_cnt <= '0;
        buzzer   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mole_keypad_game.sv
// Directed bench for mole_keypad_game with short timing parameters.
module tb_mole_keypad_game;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [7:0] led;
  logic [3:0] col;
  logic       buzzer;
  logic [15:0] keys;

  int unsigned total;
  int unsigned bad;

  mole_keypad_game #(
    .SCAN_DIV (4),
    .DEBOUNCE (2),
    .ROUND_CYC(400),
    .GAP_CYC  (20),
    .BEEP_CYC (40),
    .TONE_DIV (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .row   (row),
    .led   (led),
    .col   (col),
    .buzzer(buzzer)
  );

  function automatic logic [3:0] rows_for(input logic [3:0] c, input logic [15:0] k);
    rows_for = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (c == ~(4'b0001 << i)) rows_for = ~k[4*i +: 4];
    end
  endfunction

  assign row = rows_for(col, keys);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_led(input bit on, input int unsigned budget, output int unsigned n);
    n = 0;
    while (((led != 8'h00) !== on) && n < budget) begin
      tick();
      n++;
    end
  endtask

  function automatic int unsigned led_idx(input logic [7:0] l);
    led_idx = 0;
    for (int unsigned i = 0; i < 8; i++) if (l[i]) led_idx = i;
  endfunction

  int unsigned n;
  int unsigned k;
  logic [7:0]  exp_score;
  logic [7:0]  lit;

  initial begin
    total = 0;
    bad = 0;
    keys = '0;
    exp_score = 8'd0;
    rst_n = 1'b0;
    #23;
    check_eq("rst_led", led, 8'h00);
    check_eq("rst_col", col, 4'b1110);
    check_eq("rst_buzzer", buzzer, 1'b0);
    check_eq("rst_score", dut.score, 8'd0);
    check_eq("rst_lfsr", dut.lfsr, 8'hA5);

    // 1: gap, mole, timeout miss
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 1; i <= 19; i++) begin
      tick();
      if (i == 4)  check_eq("col_step1", col, 4'b1101);
      if (i == 16) check_eq("col_wrap", col, 4'b1110);
    end
    check_eq("gap_dark", led, 8'h00);
    tick();
    check_eq("mole_onehot", $onehot(led), 1'b1);
    lit = led;
    for (int unsigned i = 1; i < 400; i++) tick();
    check_eq("mole_held", led, lit);
    tick();
    check_eq("timeout_led", led, 8'h00);
    check_eq("timeout_score", dut.score, exp_score);
`ifdef MISS_BEEP_EN
    for (int unsigned j = 0; j < 20; j++) begin
      check_eq("miss_tone", buzzer, (j / 4) & 1);
      tick();
    end
    check_eq("miss_tone_end", buzzer, 1'b0);
`else
    check_eq("timeout_buzzer", buzzer, 1'b0);
    tick();
    check_eq("miss_quiet", buzzer, 1'b0);
`endif

    // 2: correct key -> hit, beep, score+1
    wait_led(1'b1, 100, n);
    check_eq("round2_lit", n < 100, 1'b1);
    k = led_idx(led);
    keys = 16'(1) << k;
    wait_led(1'b0, 200, n);
    check_eq("hit_fast", n < 200, 1'b1);
    keys = '0;
    exp_score++;
    check_eq("hit_score", dut.score, exp_score);
    for (int unsigned j = 0; j < 40; j++) begin
      check_eq("hit_tone", buzzer, (j / 2) & 1);
      check_eq("hit_dark", led, 8'h00);
      tick();
    end
    check_eq("hit_tone_end", buzzer, 1'b0);

    // 3: wrong game key -> miss
    wait_led(1'b1, 100, n);
    check_eq("round3_lit", n < 100, 1'b1);
    k = (led_idx(led) + 1) % 8;
    keys = 16'(1) << k;
    wait_led(1'b0, 200, n);
    check_eq("wrong_fast", n < 200, 1'b1);
    keys = '0;
    check_eq("wrong_score", dut.score, exp_score);
    check_eq("wrong_buzzer", buzzer, 1'b0);

    // 4: all keys held -> one registration until released
    wait_led(1'b1, 100, n);
    check_eq("round4_lit", n < 100, 1'b1);
    k = led_idx(led);
    keys = 16'hFFFF;
    wait_led(1'b0, 200, n);
    check_eq("held_first", n < 200, 1'b1);
    if (k == 0) exp_score++;
    check_eq("held_score", dut.score, exp_score);
    wait_led(1'b1, 200, n);
    check_eq("round5_lit", n < 200, 1'b1);
    wait_led(1'b0, 500, n);
    check_eq("lock_hold", n, 400);
    check_eq("lock_score", dut.score, exp_score);
    keys = '0;
    wait_led(1'b1, 200, n);
    check_eq("round6_lit", n < 200, 1'b1);
    k = led_idx(led);
    for (int unsigned i = 0; i < 40; i++) tick();
    keys = 16'(1) << k;
    wait_led(1'b0, 200, n);
    check_eq("release_hit", n < 200, 1'b1);
    exp_score++;
    check_eq("release_score", dut.score, exp_score);

    // 5: reset during the hit beep
    tick();
    tick();
    check_eq("beep_on", buzzer, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_buzzer", buzzer, 1'b0);
    check_eq("arst_led", led, 8'h00);
    check_eq("arst_col", col, 4'b1110);
    check_eq("arst_score", dut.score, 8'd0);
    keys = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_led", led, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
